uart_transmitter: RTL and testbench

Serial transmit half of the UART link. Accepts a parallel byte over a four-phase REQ/ACK handshake and shifts it out on a single line as one frame: start bit, 8 data bits LSB first, optional parity bit, one stop bit. Frame format and bit period match `uart_receiver`, so the two blocks connect TX-to-RX for loopback.

---
 rtl/uart_transmitter_if.sv | 25 ++
 rtl/uart_transmitter.sv | 169 ++++++++++++++++
 tb/tb_uart_transmitter.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if: producer-side REQ/ACK handshake plus serial line.
// master = byte producer, slave = transmitter.
interface uart_transmitter_if;
  logic       XMT_REQ;
  logic [7:0] XMT_Data;
  logic       XMT_ACK;
  logic       XMT_BUSY;
  logic       TXD;

  modport master (
    output XMT_REQ,
    output XMT_Data,
    input  XMT_ACK,
    input  XMT_BUSY,
    input  TXD
  );

  modport slave (
    input  XMT_REQ,
    input  XMT_Data,
    output XMT_ACK,
    output XMT_BUSY,
    output TXD
  );
endinterface

// File: rtl/uart_transmitter.sv
// uart_transmitter: serial transmit half of the UART link.
// Frame = start, 8 data LSB first, optional parity, one stop.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 32,
  parameter bit PARITY_EN    = 1'b1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input logic               clk,
  input logic               clr,
  uart_transmitter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [15:0] TC =
    16'(CLKS_PER_BIT - 1);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
  logic        r_par;
  logic        r_ack;
  logic        r_busy;
  logic        r_txd;

  state_t      w_state;
  logic [15:0] w_cnt;
  logic [2:0]  w_idx;
  logic [7:0]  w_shift;
  logic        w_par;
  logic        w_ack;
  logic        w_busy;
  logic        w_txd;
  logic        w_tc;
  logic        w_accept;

  assign w_tc     = (r_cnt == TC);
  assign w_accept = !r_ack && bus.XMT_REQ;

  assign bus.XMT_ACK  = r_ack;
  assign bus.XMT_BUSY = r_busy;
  assign bus.TXD      = r_txd;

  // Register every piece of state; clr aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_txd   <= 1'b1;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_shift <= w_shift;
      r_par   <= w_par;
      r_ack   <= w_ack;
      r_busy  <= w_busy;
      r_txd   <= w_txd;
    end
  end

  // Next state and next registered outputs; TXD is the
  // value of the bit being entered, so it is glitch-free.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_idx   = r_idx;
    w_shift = r_shift;
    w_par   = r_par;
    w_ack   = r_ack;
    w_busy  = r_busy;
    w_txd   = r_txd;

    // ACK release is independent of frame progress.
    if (r_ack && !bus.XMT_REQ) begin
      w_ack = 1'b0;
    end

    unique case (r_state)
      S_IDLE: begin
        w_txd  = 1'b1;
        w_busy = 1'b0;
        w_cnt  = '0;
        w_idx  = '0;
        if (w_accept) begin
          w_shift = bus.XMT_Data;
          w_par   = (^bus.XMT_Data) ^ PARITY_ODD;
          w_ack   = 1'b1;
          w_busy  = 1'b1;
          w_txd   = 1'b0;
          w_state = S_START;
        end
      end

      S_START: begin
        if (w_tc) begin
          w_cnt   = '0;
          w_idx   = '0;
          w_txd   = r_shift[0];
          w_state = S_DATA;
        end else begin
          w_cnt = r_cnt + 16'd1;
        end
      end

      S_DATA: begin
        if (w_tc) begin
          w_cnt = '0;
          if (r_idx == 3'd7) begin
            if (PARITY_EN) begin
              w_txd   = r_par;
              w_state = S_PARITY;
            end else begin
              w_txd   = 1'b1;
              w_state = S_STOP;
            end
          end else begin
            w_idx   = r_idx + 3'd1;
            w_shift = {1'b0, r_shift[7:1]};
            w_txd   = r_shift[1];
          end
        end else begin
          w_cnt = r_cnt + 16'd1;
        end
      end

      S_PARITY: begin
        if (w_tc) begin
          w_cnt   = '0;
          w_txd   = 1'b1;
          w_state = S_STOP;
        end else begin
          w_cnt = r_cnt + 16'd1;
        end
      end

      S_STOP: begin
        if (w_tc) begin
          w_cnt   = '0;
          w_txd   = 1'b1;
          w_busy  = 1'b0;
          w_state = S_IDLE;
        end else begin
          w_cnt = r_cnt + 16'd1;
        end
      end

      default: begin
        w_state = S_IDLE;
        w_txd   = 1'b1;
        w_busy  = 1'b0;
        w_cnt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: three transmitter configurations
// checked against a frame-level model of the serial line.
module tb_uart_transmitter;

  logic clk;
  logic clr;

  logic       r_req [3];
  logic [7:0] r_dat [3];
  logic       w_ack [3];
  logic       w_busy[3];
  logic       w_txd [3];

  int n_chk;
  int n_err;

  uart_transmitter_if if0 ();
  uart_transmitter_if if1 ();
  uart_transmitter_if if2 ();

  assign if0.XMT_REQ  = r_req[0];
  assign if0.XMT_Data = r_dat[0];
  assign if1.XMT_REQ  = r_req[1];
  assign if1.XMT_Data = r_dat[1];
  assign if2.XMT_REQ  = r_req[2];
  assign if2.XMT_Data = r_dat[2];

  assign w_ack[0]  = if0.XMT_ACK;
  assign w_busy[0] = if0.XMT_BUSY;
  assign w_txd[0]  = if0.TXD;
  assign w_ack[1]  = if1.XMT_ACK;
  assign w_busy[1] = if1.XMT_BUSY;
  assign w_txd[1]  = if1.TXD;
  assign w_ack[2]  = if2.XMT_ACK;
  assign w_busy[2] = if2.XMT_BUSY;
  assign w_txd[2]  = if2.TXD;

  uart_transmitter #(
    .CLKS_PER_BIT(32), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)
  ) u_dut0 (.clk(clk), .clr(clr), .bus(if0));

  uart_transmitter #(
    .CLKS_PER_BIT(32), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)
  ) u_dut1 (.clk(clk), .clr(clr), .bus(if1));

  uart_transmitter #(
    .CLKS_PER_BIT(2), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)
  ) u_dut2 (.clk(clk), .clr(clr), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cpb(input int u);
    return (u == 2) ? 2 : 32;
  endfunction

  function automatic bit pen(input int u);
    return (u != 2);
  endfunction

  function automatic bit podd(input int u);
    return (u == 1);
  endfunction

  function automatic int nbits(input int u);
    return pen(u) ? 11 : 10;
  endfunction

  // Expected line, index 0 = first bit on the wire.
  function automatic logic [10:0] exp_frame(
    input logic [7:0] d, input int u);
    int ones;
    logic p;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    p = (ones % 2 == 1) ^ podd(u);
    if (pen(u)) return {1'b1, p, d, 1'b0};
    return {1'b0, 1'b1, d, 1'b0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Record the line bit by bit while BUSY is high; a bit
  // that changes inside its window is recorded as X.
  task automatic capture(input int u,
                         output logic [10:0] obs,
                         output int blen);
    int c;
    int nb;
    c = cpb(u);
    nb = nbits(u);
    obs = '0;
    blen = 0;
    for (int t = 0; t < 11 * c + 20; t++) begin
      if (w_busy[u] !== 1'b1) break;
      if (t < nb * c) begin
        if (t % c == 0) obs[t / c] = w_txd[u];
        else if (w_txd[u] !== obs[t / c])
          obs[t / c] = 1'bx;
      end
      blen++;
      step();
    end
  endtask

  task automatic test_frame(input int u, input logic [7:0] d);
    logic [10:0] obs;
    int blen;
    r_dat[u] = d;
    r_req[u] = 1'b1;
    step();
    n_chk++;
    if ({w_ack[u], w_busy[u], w_txd[u]} !== 3'b110) begin
      n_err++;
      $display("FAIL accept u%0d ack/busy/txd got %b want 110",
               u, {w_ack[u], w_busy[u], w_txd[u]});
    end
    r_req[u] = 1'b0;
    r_dat[u] = ~d;
    capture(u, obs, blen);
    n_chk++;
    if (obs !== exp_frame(d, u)) begin
      n_err++;
      $display("FAIL frame u%0d d=%h got %b want %b",
               u, d, obs, exp_frame(d, u));
    end
    n_chk++;
    if (blen != nbits(u) * cpb(u)) begin
      n_err++;
      $display("FAIL busy_len u%0d got %0d want %0d",
               u, blen, nbits(u) * cpb(u));
    end
    n_chk++;
    if ({w_ack[u], w_txd[u]} !== 2'b01) begin
      n_err++;
      $display("FAIL post_frame u%0d ack/txd got %b want 01",
               u, {w_ack[u], w_txd[u]});
    end
  endtask

  task automatic test_reset();
    int bad;
    clr = 1'b1;
    repeat (3) step();
    for (int u = 0; u < 3; u++) begin
      n_chk++;
      if ({w_txd[u], w_ack[u], w_busy[u]} !== 3'b100) begin
        n_err++;
        $display("FAIL reset u%0d txd/ack/busy got %b want 100",
                 u, {w_txd[u], w_ack[u], w_busy[u]});
      end
    end
    clr = 1'b0;
    step();
    r_dat[0] = 8'h33;
    r_req[0] = 1'b1;
    step();
    r_req[0] = 1'b0;
    repeat (50) step();
    clr = 1'b1;
    r_req[0] = 1'b1;
    step();
    n_chk++;
    if ({w_txd[0], w_ack[0], w_busy[0]} !== 3'b100) begin
      n_err++;
      $display("FAIL midframe_clr txd/ack/busy got %b want 100",
               {w_txd[0], w_ack[0], w_busy[0]});
    end
    step();
    step();
    n_chk++;
    if ({w_txd[0], w_ack[0], w_busy[0]} !== 3'b100) begin
      n_err++;
      $display("FAIL clr_wins txd/ack/busy got %b want 100",
               {w_txd[0], w_ack[0], w_busy[0]});
    end
    clr = 1'b0;
    r_req[0] = 1'b0;
    bad = 0;
    repeat (100) begin
      step();
      if (w_txd[0] !== 1'b1 || w_busy[0] !== 1'b0) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL idle_after_clr bad cycles got %0d want 0",
               bad);
    end
  endtask

  task automatic test_known_answers();
    logic [10:0] obs;
    logic [10:0] want;
    int blen;
    r_dat[0] = 8'h54;
    r_req[0] = 1'b1;
    step();
    r_req[0] = 1'b0;
    capture(0, obs, blen);
    want = 11'b1_1_01010100_0;
    n_chk++;
    if (obs !== want || blen != 352) begin
      n_err++;
      $display("FAIL byte_54 got %b/%0d want %b/352",
               obs, blen, want);
    end
    test_frame(0, 8'h5A);
    test_frame(1, 8'h5A);
    r_dat[1] = 8'h5A;
    r_req[1] = 1'b1;
    step();
    r_req[1] = 1'b0;
    capture(1, obs, blen);
    want = 11'b1_1_01011010_0;
    n_chk++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL byte_5A_odd got %b want %b", obs, want);
    end
    r_dat[2] = 8'h81;
    r_req[2] = 1'b1;
    step();
    r_req[2] = 1'b0;
    capture(2, obs, blen);
    want = 11'b0_1_10000001_0;
    n_chk++;
    if (obs !== want || blen != 20) begin
      n_err++;
      $display("FAIL byte_81_nopar got %b/%0d want %b/20",
               obs, blen, want);
    end
  endtask

  task automatic test_handshake();
    logic [10:0] obs;
    int blen;
    int ack_low;
    int bad;
    r_dat[0] = 8'hA5;
    r_req[0] = 1'b1;
    step();
    ack_low = 0;
    fork
      capture(0, obs, blen);
      begin
        for (int t = 0; t < 352; t++) begin
          if (w_ack[0] !== 1'b1) ack_low++;
          if (t == 40) r_dat[0] = 8'($urandom);
          step();
        end
      end
    join
    n_chk++;
    if (obs !== exp_frame(8'hA5, 0) || blen != 352) begin
      n_err++;
      $display("FAIL hold_frame got %b/%0d want %b/352",
               obs, blen, exp_frame(8'hA5, 0));
    end
    bad = 0;
    for (int t = 353; t < 500; t++) begin
      if (w_ack[0] !== 1'b1) ack_low++;
      if (w_busy[0] !== 1'b0 || w_txd[0] !== 1'b1) bad++;
      step();
    end
    n_chk++;
    if (ack_low != 0 || bad != 0) begin
      n_err++;
      $display("FAIL hold_single ack_low=%0d retrig=%0d want 0/0",
               ack_low, bad);
    end
    r_req[0] = 1'b0;
    n_chk++;
    if (w_ack[0] !== 1'b1) begin
      n_err++;
      $display("FAIL ack_early got %b want 1", w_ack[0]);
    end
    step();
    n_chk++;
    if (w_ack[0] !== 1'b0) begin
      n_err++;
      $display("FAIL ack_release got %b want 0", w_ack[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] obs1;
    logic [10:0] obs2;
    int b1;
    int b2;
    step();
    r_dat[0] = 8'h00;
    r_req[0] = 1'b1;
    step();
    r_req[0] = 1'b0;
    fork
      capture(0, obs1, b1);
      begin
        repeat (100) step();
        r_dat[0] = 8'hFF;
        r_req[0] = 1'b1;
      end
    join
    n_chk++;
    if (obs1 !== exp_frame(8'h00, 0) || b1 != 352) begin
      n_err++;
      $display("FAIL b2b_first got %b/%0d want %b/352",
               obs1, b1, exp_frame(8'h00, 0));
    end
    n_chk++;
    if (w_txd[0] !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_gap_txd got %b want 1", w_txd[0]);
    end
    step();
    n_chk++;
    if ({w_busy[0], w_txd[0]} !== 2'b10) begin
      n_err++;
      $display("FAIL b2b_second_start busy/txd got %b want 10",
               {w_busy[0], w_txd[0]});
    end
    r_req[0] = 1'b0;
    capture(0, obs2, b2);
    n_chk++;
    if (obs2 !== exp_frame(8'hFF, 0) || b2 != 352) begin
      n_err++;
      $display("FAIL b2b_second got %b/%0d want %b/352",
               obs2, b2, exp_frame(8'hFF, 0));
    end
  endtask

  task automatic test_random();
    int u;
    for (int i = 0; i < 12; i++) begin
      u = int'($urandom_range(0, 2));
      repeat ($urandom_range(0, 5)) step();
      test_frame(u, 8'($urandom));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    clr = 1'b1;
    for (int u = 0; u < 3; u++) begin
      r_req[u] = 1'b0;
      r_dat[u] = 8'h00;
    end
    step();
    test_reset();
    test_known_answers();
    test_handshake();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
